// File: rtl/moving_average_mc.sv
// Multi-channel boxcar averager: per-channel sample ring plus running sum,
// rounded result one cycle after each accepted sample.
module moving_average_mc #(
  parameter  int DATA_W       = 16,
  parameter  int CHANNELS     = 4,
  parameter  int LOG2_MAX_WIN = 6,
  localparam int CW           = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int WW           = $clog2(LOG2_MAX_WIN + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CW-1:0]     in_chan,
  input  logic [WW-1:0]     window_log2,
  input  logic              clear,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [CW-1:0]     out_chan,
  output logic              out_full,
  output logic              err_chan
);

  localparam int LW    = LOG2_MAX_WIN;
  localparam int DEPTH = 1 << LW;
  localparam int AW    = DATA_W + LW;

  logic [WW-1:0]        k_reg;
  logic signed [AW-1:0] acc_reg  [CHANNELS];
  logic [LW-1:0]        wptr_reg [CHANNELS];
  logic [LW:0]          fill_reg [CHANNELS];
  logic [DATA_W-1:0]    ring     [CHANNELS*DEPTH];

  logic [WW-1:0]        k_clamped;
  logic [WW-1:0]        k_eff;
  logic                 flush;
  logic                 accept;
  logic [LW:0]          win;
  logic signed [AW-1:0] cur_acc;
  logic [LW-1:0]        cur_wptr;
  logic [LW:0]          cur_fill;
  logic [LW-1:0]        old_addr;
  logic [DATA_W-1:0]    oldest;
  logic signed [AW-1:0] acc_next;
  logic [LW:0]          fill_next;
  logic signed [AW:0]   rnd;
  logic signed [AW:0]   rounded_sum;
  logic [DATA_W-1:0]    avg;

  always_comb begin
    k_clamped = (window_log2 > WW'(LOG2_MAX_WIN)) ? WW'(LOG2_MAX_WIN) : window_log2;
    flush     = clear || (k_clamped != k_reg);
    // A flush takes effect on this edge, so a concurrent sample already sees the new window.
    k_eff     = flush ? k_clamped : k_reg;
    accept    = in_valid && ({1'b0, in_chan} < (CW+1)'(CHANNELS));
    win       = (LW+1)'(1) << k_eff;

    cur_acc   = flush ? '0 : acc_reg[in_chan];
    cur_wptr  = flush ? '0 : wptr_reg[in_chan];
    cur_fill  = flush ? '0 : fill_reg[in_chan];

    // At the maximum window the low bits of win are zero, so this is the slot being overwritten.
    old_addr  = cur_wptr - win[LW-1:0];
    oldest    = ring[{in_chan, old_addr}];

    if (cur_fill < win) begin
      acc_next  = cur_acc + {{LW{in_data[DATA_W-1]}}, in_data};
      fill_next = cur_fill + 1'b1;
    end else begin
      acc_next  = cur_acc + {{LW{in_data[DATA_W-1]}}, in_data}
                          - {{LW{oldest[DATA_W-1]}}, oldest};
      fill_next = cur_fill;
    end

    rnd = '0;
    if (k_eff != '0) rnd = (AW+1)'(1) << (k_eff - WW'(1));
    rounded_sum = {acc_next[AW-1], acc_next} + rnd;
    avg         = DATA_W'(rounded_sum >>> k_eff);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      k_reg     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      out_full  <= 1'b0;
      err_chan  <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        acc_reg[i]  <= '0;
        wptr_reg[i] <= '0;
        fill_reg[i] <= '0;
      end
    end else begin
      k_reg     <= k_clamped;
      out_valid <= accept;
      err_chan  <= in_valid && !accept;
      for (int i = 0; i < CHANNELS; i++) begin
        if (accept && (in_chan == CW'(i))) begin
          acc_reg[i]  <= acc_next;
          wptr_reg[i] <= cur_wptr + 1'b1;
          fill_reg[i] <= fill_next;
        end else if (flush) begin
          acc_reg[i]  <= '0;
          wptr_reg[i] <= '0;
          fill_reg[i] <= '0;
        end
      end
      if (accept) begin
        out_data <= avg;
        out_chan <= in_chan;
        out_full <= (fill_next == win);
      end
    end
  end

  // Sample storage is plain RAM: no reset, a stale slot is never read before being rewritten.
  always_ff @(posedge clk) begin
    if (accept) ring[{in_chan, cur_wptr}] <= in_data;
  end

endmodule

// File: tb/tb_moving_average_mc.sv
// Directed bench for moving_average_mc with a history-based reference model
// feeding a scoreboard queue that a monitor drains one cycle after each sample.
module tb_moving_average_mc;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [15:0] in_data;
  logic [1:0]  in_chan;
  logic [2:0]  window_log2;
  logic        clear;
  logic        out_valid;
  logic [15:0] out_data;
  logic [1:0]  out_chan;
  logic        out_full;
  logic        err_chan;

  logic        in2_valid;
  logic [15:0] in2_data;
  logic [2:0]  in2_chan;
  logic [2:0]  window2;
  logic        clear2;
  logic        out2_valid;
  logic [15:0] out2_data;
  logic [2:0]  out2_chan;
  logic        out2_full;
  logic        err2_chan;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int data;
    int chan;
    int full;
  } exp_t;

  exp_t q[$];
  int   hist[4][$];
  int   mk = 0;

  always #5 clk = ~clk;

  moving_average_mc dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_chan(in_chan), .window_log2(window_log2), .clear(clear),
    .out_valid(out_valid), .out_data(out_data), .out_chan(out_chan),
    .out_full(out_full), .err_chan(err_chan)
  );

  moving_average_mc #(.DATA_W(16), .CHANNELS(5), .LOG2_MAX_WIN(6)) dut5 (
    .clk(clk), .reset(reset), .in_valid(in2_valid), .in_data(in2_data),
    .in_chan(in2_chan), .window_log2(window2), .clear(clear2),
    .out_valid(out2_valid), .out_data(out2_data), .out_chan(out2_chan),
    .out_full(out2_full), .err_chan(err2_chan)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 4; c++) hist[c].delete();
    mk = 0;
  endtask

  // Drive one cycle at a falling edge, update the model, push the expected result.
  task automatic step(input bit v, input int ch, input int d, input int wl, input bit clr);
    int   kc;
    int   sum;
    exp_t e;
    in_valid    = v;
    in_chan     = 2'(ch);
    in_data     = 16'(d);
    window_log2 = 3'(wl);
    clear       = clr;
    kc = (wl > 6) ? 6 : wl;
    if (clr || kc != mk) for (int c = 0; c < 4; c++) hist[c].delete();
    mk = kc;
    if (v && ch < 4) begin
      hist[ch].push_back(d);
      if (hist[ch].size() > (1 << mk)) void'(hist[ch].pop_front());
      sum = 0;
      for (int j = 0; j < hist[ch].size(); j++) sum += hist[ch][j];
      if (mk > 0) sum = (sum + (1 << (mk - 1))) >>> mk;
      e.data = sum;
      e.chan = ch;
      e.full = (hist[ch].size() == (1 << mk)) ? 1 : 0;
      q.push_back(e);
    end
    @(negedge clk);
  endtask

  // Every expectation pushed before an edge must appear right after that edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (reset && (q.size() > 0 || out_valid)) begin
      chk("out_valid", int'(out_valid), (q.size() > 0) ? 1 : 0);
      if (q.size() > 0) begin
        e = q.pop_front();
        $display("txn chan=%0d data=%0d full=%0d", out_chan, $signed(out_data), out_full);
        chk("out_data", int'($signed(out_data)), e.data);
        chk("out_chan", int'(out_chan), e.chan);
        chk("out_full", int'(out_full), e.full);
      end
    end
  end

  initial begin
    reset = 1'b1;
    in_valid = 1'b0; in_data = '0; in_chan = '0; window_log2 = '0; clear = 1'b0;
    in2_valid = 1'b0; in2_data = '0; in2_chan = '0; window2 = '0; clear2 = 1'b0;
    #1 reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_out_chan", int'(out_chan), 0);
    chk("rst_out_full", int'(out_full), 0);
    chk("rst_err_chan", int'(err_chan), 0);
    reset = 1'b1;
    model_reset();
    @(negedge clk);

    // Window 4 fill and steady state on ch0
    step(1, 0, 4, 2, 0);
    step(1, 0, 8, 2, 0);
    step(1, 0, 12, 2, 0);
    step(1, 0, 16, 2, 0);
    step(1, 0, 20, 2, 0);
    step(0, 0, 0, 2, 0);

    // Window 2, interleaved opposite-sign channels
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 100, 1, 0);
      step(1, 1, -100, 1, 0);
    end

    // Negative rounding, then window 1
    step(1, 2, -3, 1, 0);
    step(1, 2, 0, 1, 0);
    step(1, 2, 7, 0, 0);
    step(0, 0, 0, 0, 0);

    // Full-scale at the maximum window, ring wraps twice
    for (int i = 0; i < 64; i++) step(1, 3, 32767, 6, 0);
    for (int i = 0; i < 64; i++) step(1, 3, -32768, 6, 0);
    step(0, 0, 0, 6, 0);

    // Steady state at window 8, then a window change with a concurrent sample
    for (int i = 0; i < 10; i++) step(1, 0, 10, 3, 0);
    for (int i = 0; i < 4; i++) step(1, 1, 20, 3, 0);
    step(1, 0, 40, 2, 0);
    step(1, 1, 8, 2, 0);
    step(1, 0, 64, 7, 0);
    step(1, 0, 64, 6, 0);
    step(1, 0, 64, 6, 1);
    step(0, 0, 0, 6, 0);
    chk("main_err_quiet", int'(err_chan), 0);

    // Out-of-range channel on a five-channel instance
    in2_valid = 1'b1; in2_chan = 3'd5; in2_data = 16'd123;
    step(0, 0, 0, 6, 0);
    chk("err_pulse", int'(err2_chan), 1);
    chk("err_no_valid", int'(out2_valid), 0);
    in2_chan = 3'd4; in2_data = 16'd9;
    step(0, 0, 0, 6, 0);
    chk("err_single_cycle", int'(err2_chan), 0);
    chk("ch4_valid", int'(out2_valid), 1);
    chk("ch4_data", int'(out2_data), 9);
    chk("ch4_chan", int'(out2_chan), 4);
    chk("ch4_full", int'(out2_full), 1);
    in2_valid = 1'b0;
    step(0, 0, 0, 6, 0);
    chk("ch4_pulse_end", int'(out2_valid), 0);

    // Mid-stream reset with a sample in flight
    for (int i = 0; i < 3; i++) step(1, 1, 16, 3, 0);
    in_valid = 1'b1; in_chan = 2'd1; in_data = 16'd16;
    #2 reset = 1'b0;
    #1;
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_out_data", int'(out_data), 0);
    chk("midrst_out_chan", int'(out_chan), 0);
    chk("midrst_out_full", int'(out_full), 0);
    model_reset();
    @(negedge clk);
    in_valid = 1'b0;
    reset = 1'b1;
    step(1, 1, 8, 3, 0);
    step(0, 0, 0, 3, 0);
    step(0, 0, 0, 3, 0);
    chk("scoreboard_drained", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
